// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch history table + branch target buffer.
// Zero-latency lookup for IF; EX resolves and trains the table; saturating branch statistics.
module branch_predictor_btb #(
   parameter int unsigned ENTRIES = 64,
   parameter int unsigned TAG_W   = 8,
   parameter int unsigned CTR_W   = 2,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [29:0]      if_pc,
   output logic             pred_hit,
   output logic             pred_taken,
   output logic [29:0]      pred_target,
   input  logic             upd_en,
   input  logic [29:0]      upd_pc,
   input  logic             upd_taken,
   input  logic [29:0]      upd_target,
   input  logic             upd_mispredict,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispredict_cnt
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);

   localparam logic [CTR_W-1:0] CtrWeakT  = CTR_W'(1) << (CTR_W - 1);
   localparam logic [CTR_W-1:0] CtrWeakNt = CtrWeakT - CTR_W'(1);
   localparam logic [CTR_W-1:0] CtrMax    = {CTR_W{1'b1}};
   localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

   logic             valid_q  [ENTRIES];
   logic             valid_d  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [TAG_W-1:0] tag_d    [ENTRIES];
   logic [29:0]      target_q [ENTRIES];
   logic [29:0]      target_d [ENTRIES];
   logic [CTR_W-1:0] ctr_q    [ENTRIES];
   logic [CTR_W-1:0] ctr_d    [ENTRIES];

   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             up_hit;

   assign lk_idx = if_pc[IDX_W-1:0];
   assign lk_tag = if_pc[IDX_W+TAG_W-1:IDX_W];
   assign up_idx = upd_pc[IDX_W-1:0];
   assign up_tag = upd_pc[IDX_W+TAG_W-1:IDX_W];
   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   // Lookup reads the registered table, so a same-cycle update is not yet visible.
   always_comb begin
      pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_taken  = pred_hit && ctr_q[lk_idx][CTR_W-1];
      pred_target = pred_taken ? target_q[lk_idx] : (if_pc + 30'd1);
   end

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (upd_en) begin
         if (up_hit) begin
            if (upd_taken) begin
               target_d[up_idx] = upd_target;
               if (ctr_q[up_idx] != CtrMax) ctr_d[up_idx] = ctr_q[up_idx] + CTR_W'(1);
            end else if (ctr_q[up_idx] != '0) begin
               ctr_d[up_idx] = ctr_q[up_idx] - CTR_W'(1);
            end
         end else if (upd_taken) begin
            // Taken miss allocates, evicting whatever aliased into this index.
            valid_d[up_idx]  = 1'b1;
            tag_d[up_idx]    = up_tag;
            target_d[up_idx] = upd_target;
            ctr_d[up_idx]    = CtrWeakT;
         end
      end
   end

   always_comb begin
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (upd_en) begin
         if (branch_cnt_q != CntMax) branch_cnt_d = branch_cnt_q + CNT_W'(1);
         if (upd_mispredict && (mispredict_cnt_q != CntMax)) begin
            mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CtrWeakNt;
         end
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         valid_q          <= valid_d;
         tag_q            <= tag_d;
         target_q         <= target_d;
         ctr_q            <= ctr_d;
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: scoreboarded lookups, training, aliasing,
// read-before-write, async reset and counter saturation (second instance with CNT_W=4).
module tb_branch_predictor_btb;

   logic        clk = 1'b0;
   logic        rst;
   logic [29:0] if_pc;
   logic        pred_hit, pred_taken;
   logic [29:0] pred_target;
   logic        upd_en, upd_taken, upd_mispredict;
   logic [29:0] upd_pc, upd_target;
   logic [31:0] branch_cnt, mispredict_cnt;

   logic        hit4, taken4;
   logic [29:0] target4;
   logic [3:0]  branch_cnt4, mispredict_cnt4;

   int checks = 0;
   int errors = 0;
   int exp_b  = 0;
   int exp_m  = 0;

   typedef struct {
      logic        hit;
      logic        taken;
      logic [29:0] target;
      string       name;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   branch_predictor_btb dut (
      .clk(clk), .rst(rst), .if_pc(if_pc),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_mispredict(upd_mispredict),
      .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
   );

   branch_predictor_btb #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .if_pc(if_pc),
      .pred_hit(hit4), .pred_taken(taken4), .pred_target(target4),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_mispredict(upd_mispredict),
      .branch_cnt(branch_cnt4), .mispredict_cnt(mispredict_cnt4)
   );

   // Push expectation, drive the lookup, then pop and compare once outputs settle.
   task automatic lookup(input logic [29:0] pc, input logic hit, input logic taken,
                         input logic [29:0] tgt, input string name);
      exp_t e;
      exp_q.push_back('{hit: hit, taken: taken, target: tgt, name: name});
      if_pc = pc;
      #1;
      e = exp_q.pop_front();
      checks++;
      if (pred_hit !== e.hit || pred_taken !== e.taken || pred_target !== e.target) begin
         errors++;
         $display("FAIL %s: got hit=%b taken=%b target=%h, expected hit=%b taken=%b target=%h",
                  e.name, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.target);
      end
   endtask

   task automatic update(input logic [29:0] pc, input logic taken, input logic [29:0] tgt,
                         input logic mis);
      @(negedge clk);
      upd_en = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt; upd_mispredict = mis;
      exp_b++;
      if (mis) exp_m++;
      @(negedge clk);
      upd_en = 1'b0; upd_mispredict = 1'b0;
   endtask

   task automatic check_counts(input string name);
      checks++;
      if (branch_cnt !== 32'(exp_b) || mispredict_cnt !== 32'(exp_m)) begin
         errors++;
         $display("FAIL %s: got branch=%0d mispredict=%0d, expected branch=%0d mispredict=%0d",
                  name, branch_cnt, mispredict_cnt, exp_b, exp_m);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; if_pc = 30'h100;
      upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
      #2;
      lookup(30'h100, 1'b0, 1'b0, 30'h101, "during_reset");
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      lookup(30'h100, 1'b0, 1'b0, 30'h101, "after_reset");
      check_counts("reset_counts");
   endtask

   task automatic test_train();
      update(30'h100, 1'b1, 30'h80, 1'b1);
      lookup(30'h100, 1'b1, 1'b1, 30'h80, "alloc_hit");
      check_counts("alloc_counts");
      repeat (3) update(30'h100, 1'b1, 30'h80, 1'b0);
      update(30'h100, 1'b0, 30'h0, 1'b1);
      lookup(30'h100, 1'b1, 1'b1, 30'h80, "sat_then_one_nt");
      update(30'h100, 1'b0, 30'h0, 1'b1);
      lookup(30'h100, 1'b1, 1'b0, 30'h101, "two_nt_predict_nt");
      check_counts("train_counts");
      // Ignored: mispredict without upd_en.
      @(negedge clk); upd_mispredict = 1'b1;
      @(negedge clk); upd_mispredict = 1'b0;
      check_counts("mispredict_unqualified");
   endtask

   task automatic test_alias();
      update(30'h100, 1'b1, 30'h80, 1'b0);
      lookup(30'h100, 1'b1, 1'b1, 30'h80, "hit_taken_retarget");
      update(30'h140, 1'b1, 30'h20, 1'b1);
      lookup(30'h100, 1'b0, 1'b0, 30'h101, "evicted_miss");
      lookup(30'h140, 1'b1, 1'b1, 30'h20, "alias_alloc");
      update(30'h100, 1'b0, 30'h3, 1'b0);
      lookup(30'h140, 1'b1, 1'b1, 30'h20, "nt_miss_no_change");
      lookup(30'h100, 1'b0, 1'b0, 30'h101, "nt_miss_no_alloc");
      update(30'h4100, 1'b1, 30'h77, 1'b0);
      lookup(30'h100, 1'b1, 1'b1, 30'h77, "alias_above_tag");
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      upd_en = 1'b1; upd_pc = 30'h200; upd_taken = 1'b1; upd_target = 30'h55;
      exp_b++;
      lookup(30'h200, 1'b0, 1'b0, 30'h201, "read_before_write");
      @(posedge clk); #1;
      upd_en = 1'b0;
      lookup(30'h200, 1'b1, 1'b1, 30'h55, "write_visible_next");
      lookup(30'h3FFFFFFF, 1'b0, 1'b0, 30'h0, "pc_wrap");
      check_counts("b2b_counts");
   endtask

   task automatic test_async_reset();
      @(negedge clk); #2;
      rst = 1'b1;
      exp_b = 0; exp_m = 0;
      lookup(30'h200, 1'b0, 1'b0, 30'h201, "async_reset_drop");
      check_counts("async_reset_counts");
      @(negedge clk); #2;
      rst = 1'b0;
      lookup(30'h200, 1'b0, 1'b0, 30'h201, "post_reset_miss");
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 20; i++) update(30'(i), 1'b0, 30'h0, (i < 17));
      check_counts("wide_counts");
      checks++;
      if (branch_cnt4 !== 4'hF || mispredict_cnt4 !== 4'hF) begin
         errors++;
         $display("FAIL sat_cnt4: got branch=%0d mispredict=%0d, expected branch=15 mispredict=15",
                  branch_cnt4, mispredict_cnt4);
      end
   endtask

   initial begin
      test_reset();
      test_train();
      test_alias();
      test_back_to_back();
      test_async_reset();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
